// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer in front of one i2c_master: a register write, or a
// pointer write followed by a read, finishing with a single response pulse.
module i2c_reg_ctrl #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [2:0]  cmd_len,
    input  logic [47:0] wr_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_err,
    output logic [47:0] rd_data,
    output logic        m_start,
    input  logic        m_ready,
    output logic        m_read_nwrite,
    output logic [6:0]  m_addr,
    output logic [2:0]  m_data_size,
    output logic [7:0]  m_data_i,
    output logic        m_data_valid,
    input  logic        m_data_request,
    input  logic        m_data_available,
    input  logic [7:0]  m_data_o
);
    // state   | meaning
    // IDLE    | waiting for a command, cmd_ready high
    // W_START | start held for the write / pointer-write transaction
    // W_RUN   | feeding bytes to the master on m_data_request rises
    // R_START | start held for the read transaction
    // R_RUN   | capturing bytes on m_data_available rises
    // RESP    | one-cycle response pulse
    typedef enum logic [2:0] {IDLE, W_START, W_RUN, R_START, R_RUN, RESP} state_t;

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [1:0]    err_nxt;
    logic          rw_q;
    logic [2:0]    len_q;
    logic [7:0]    reg_q;
    logic [47:0]   wr_q;
    logic          req_d, avail_d;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    tx_idx, rx_idx, req_cnt;
    logic          accept, len_bad, req_rise, avail_rise;
    logic [55:0]   tx_bytes;
    logic [2:0]    tx_inc;

    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign len_bad    = (cmd_len == 3'd0) || (cmd_len == 3'd7);
    assign req_rise   = m_data_request & ~req_d;
    assign avail_rise = m_data_available & ~avail_d;
    assign tx_bytes   = {wr_q, reg_q};
    assign tx_inc     = tx_idx + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = len_bad ? RESP : W_START;
                    err_nxt   = len_bad ? 2'd3 : 2'd0;
                end
            end
            W_START, R_START: begin
                if (!m_ready) begin
                    state_nxt = (state == W_START) ? W_RUN : R_RUN;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = RESP;
                    err_nxt   = 2'd2;
                end
            end
            W_RUN: begin
                if (m_ready) begin
                    if (req_cnt < m_data_size) begin
                        state_nxt = RESP;
                        err_nxt   = 2'd1;
                    end else if (!rw_q) begin
                        state_nxt = RESP;
                        err_nxt   = 2'd0;
                    end else begin
                        state_nxt = R_START;
                    end
                end
            end
            R_RUN: begin
                if (m_ready) begin
                    state_nxt = RESP;
                    err_nxt   = (rx_idx < len_q) ? 2'd1 : 2'd0;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_q          <= 1'b0;
            len_q         <= 3'd0;
            reg_q         <= 8'd0;
            wr_q          <= 48'd0;
            req_d         <= 1'b0;
            avail_d       <= 1'b0;
            tmo_cnt       <= '0;
            tx_idx        <= 3'd0;
            rx_idx        <= 3'd0;
            req_cnt       <= 3'd0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 2'd0;
            rd_data       <= 48'd0;
            m_start       <= 1'b0;
            m_read_nwrite <= 1'b0;
            m_addr        <= 7'd0;
            m_data_size   <= 3'd0;
            m_data_i      <= 8'd0;
            m_data_valid  <= 1'b0;
        end else begin
            req_d        <= m_data_request;
            avail_d      <= m_data_available;
            rsp_valid    <= (state_nxt == RESP);
            rsp_err      <= err_nxt;
            m_start      <= (state_nxt == W_START) || (state_nxt == R_START);
            m_data_valid <= (state_nxt == W_RUN);
            tmo_cnt      <= (state == W_START || state == R_START) ? tmo_cnt + 1'b1 : '0;

            if (accept) begin
                rw_q          <= cmd_rw;
                len_q         <= cmd_len;
                reg_q         <= cmd_reg;
                wr_q          <= wr_data;
                rd_data       <= 48'd0;
                tx_idx        <= 3'd0;
                rx_idx        <= 3'd0;
                req_cnt       <= 3'd0;
                m_addr        <= cmd_dev;
                m_read_nwrite <= 1'b0;
                m_data_size   <= cmd_rw ? 3'd1 : cmd_len + 3'd1;
                m_data_i      <= cmd_reg;
            end

            // The first request rise is the address phase; byte 0 is already presented.
            if (state == W_RUN && req_rise) begin
                if (req_cnt != 3'd7) req_cnt <= req_cnt + 3'd1;
                if (req_cnt != 3'd0 && tx_idx != 3'd7) begin
                    tx_idx   <= tx_inc;
                    m_data_i <= (tx_inc == 3'd7) ? 8'd0 : tx_bytes[8*tx_inc +: 8];
                end
            end

            if (state == W_RUN && state_nxt == R_START) begin
                m_read_nwrite <= 1'b1;
                m_data_size   <= len_q;
                rx_idx        <= 3'd0;
            end

            if (state == R_RUN && avail_rise) begin
                if (rx_idx < 3'd6) rd_data[8*rx_idx +: 8] <= m_data_o;
                if (rx_idx != 3'd7) rx_idx <= rx_idx + 3'd1;
            end
        end
    end
endmodule
